// File: rtl/pipe_hazard_sched.sv
// Control-path scheduler for a 5-stage MIPS pipeline: carries decoded control ID->EX->MEM->WB,
// resolves load-use / branch / memory-wait hazards and drives EX operand forwarding selects.
module pipe_hazard_sched #(
    parameter int unsigned RAW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_reg_w,
    input  logic           id_mem_to_reg,
    input  logic           id_mem_write,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] id_dst,
    input  logic           id_uses_rs,
    input  logic           id_uses_rt,
    input  logic           ex_pc_src,
    input  logic           dmem_ready,
    output logic           pc_en,
    output logic           ifid_en,
    output logic           ifid_flush,
    output logic           dmem_req,
    output logic           ex_mem_to_reg,
    output logic           ex_mem_write,
    output logic           ex_reg_w,
    output logic           mem_mem_to_reg,
    output logic           mem_mem_write,
    output logic           mem_reg_w,
    output logic           wb_mem_to_reg,
    output logic           wb_reg_w,
    output logic [RAW-1:0] wb_dst,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b
);

    typedef enum logic [1:0] {
        ModeNormal,
        ModeLoadUse,
        ModeFlush,
        ModeFreeze
    } mode_e;

    localparam logic [RAW-1:0] RegZero = '0;

    // EX stage
    logic           ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic           ex_mem_write_q, ex_mem_write_d;
    logic           ex_reg_w_q, ex_reg_w_d;
    logic [RAW-1:0] ex_rs_q, ex_rs_d;
    logic [RAW-1:0] ex_rt_q, ex_rt_d;
    logic [RAW-1:0] ex_dst_q, ex_dst_d;
    // MEM stage
    logic           mem_mem_to_reg_q, mem_mem_to_reg_d;
    logic           mem_mem_write_q, mem_mem_write_d;
    logic           mem_reg_w_q, mem_reg_w_d;
    logic [RAW-1:0] mem_dst_q, mem_dst_d;
    // WB stage
    logic           wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic           wb_reg_w_q, wb_reg_w_d;
    logic [RAW-1:0] wb_dst_q, wb_dst_d;

    logic  freeze;
    logic  flush;
    logic  load_use;
    logic  rs_hit;
    logic  rt_hit;
    mode_e mode;

    assign dmem_req = mem_mem_to_reg_q | mem_mem_write_q;
    assign freeze   = dmem_req & ~dmem_ready;
    assign flush    = ex_pc_src & ~freeze;

    assign rs_hit   = id_uses_rs & (id_rs == ex_dst_q);
    assign rt_hit   = id_uses_rt & (id_rt == ex_dst_q);
    assign load_use = ex_mem_to_reg_q & (ex_dst_q != RegZero) & (rs_hit | rt_hit);

    always_comb begin
        mode = ModeNormal;
        if (freeze) begin
            mode = ModeFreeze;
        end else if (flush) begin
            mode = ModeFlush;
        end else if (load_use) begin
            mode = ModeLoadUse;
        end
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        unique case (mode)
            ModeFreeze: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
            end
            ModeFlush: begin
                ifid_flush = 1'b1;
            end
            ModeLoadUse: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
            end
            ModeNormal: begin
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        ex_mem_to_reg_d  = ex_mem_to_reg_q;
        ex_mem_write_d   = ex_mem_write_q;
        ex_reg_w_d       = ex_reg_w_q;
        ex_rs_d          = ex_rs_q;
        ex_rt_d          = ex_rt_q;
        ex_dst_d         = ex_dst_q;
        mem_mem_to_reg_d = mem_mem_to_reg_q;
        mem_mem_write_d  = mem_mem_write_q;
        mem_reg_w_d      = mem_reg_w_q;
        mem_dst_d        = mem_dst_q;
        wb_mem_to_reg_d  = 1'b0;
        wb_reg_w_d       = 1'b0;
        wb_dst_d         = RegZero;

        // Freeze keeps EX/MEM and lets WB drain to a bubble so no regfile write repeats.
        if (mode != ModeFreeze) begin
            wb_mem_to_reg_d  = mem_mem_to_reg_q;
            wb_reg_w_d       = mem_reg_w_q;
            wb_dst_d         = mem_dst_q;
            mem_mem_to_reg_d = ex_mem_to_reg_q;
            mem_mem_write_d  = ex_mem_write_q;
            mem_reg_w_d      = ex_reg_w_q;
            mem_dst_d        = ex_dst_q;
            if (mode == ModeNormal) begin
                ex_mem_to_reg_d = id_mem_to_reg;
                ex_mem_write_d  = id_mem_write;
                ex_reg_w_d      = id_reg_w;
                ex_rs_d         = id_rs;
                ex_rt_d         = id_rt;
                ex_dst_d        = id_dst;
            end else begin
                ex_mem_to_reg_d = 1'b0;
                ex_mem_write_d  = 1'b0;
                ex_reg_w_d      = 1'b0;
                ex_rs_d         = RegZero;
                ex_rt_d         = RegZero;
                ex_dst_d        = RegZero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem_to_reg_q  <= 1'b0;
            ex_mem_write_q   <= 1'b0;
            ex_reg_w_q       <= 1'b0;
            ex_rs_q          <= '0;
            ex_rt_q          <= '0;
            ex_dst_q         <= '0;
            mem_mem_to_reg_q <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_reg_w_q      <= 1'b0;
            mem_dst_q        <= '0;
            wb_mem_to_reg_q  <= 1'b0;
            wb_reg_w_q       <= 1'b0;
            wb_dst_q         <= '0;
        end else begin
            ex_mem_to_reg_q  <= ex_mem_to_reg_d;
            ex_mem_write_q   <= ex_mem_write_d;
            ex_reg_w_q       <= ex_reg_w_d;
            ex_rs_q          <= ex_rs_d;
            ex_rt_q          <= ex_rt_d;
            ex_dst_q         <= ex_dst_d;
            mem_mem_to_reg_q <= mem_mem_to_reg_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_reg_w_q      <= mem_reg_w_d;
            mem_dst_q        <= mem_dst_d;
            wb_mem_to_reg_q  <= wb_mem_to_reg_d;
            wb_reg_w_q       <= wb_reg_w_d;
            wb_dst_q         <= wb_dst_d;
        end
    end

    // MEM result is newer than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [RAW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_reg_w_q && (mem_dst_q != RegZero) && (mem_dst_q == src)) begin
            sel = 2'b10;
        end else if (wb_reg_w_q && (wb_dst_q != RegZero) && (wb_dst_q == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_rs_q);
    assign fwd_b = fwd_sel(ex_rt_q);

    assign ex_mem_to_reg  = ex_mem_to_reg_q;
    assign ex_mem_write   = ex_mem_write_q;
    assign ex_reg_w       = ex_reg_w_q;
    assign mem_mem_to_reg = mem_mem_to_reg_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign mem_reg_w      = mem_reg_w_q;
    assign wb_mem_to_reg  = wb_mem_to_reg_q;
    assign wb_reg_w       = wb_reg_w_q;
    assign wb_dst         = wb_dst_q;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Scoreboard bench for pipe_hazard_sched: a per-instruction pipeline model predicts every
// cycle's outputs, a monitor compares them mid-cycle against the DUT.
module tb_pipe_hazard_sched;

    localparam int unsigned RAW = 5;
    localparam int unsigned OW  = 16 + RAW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           id_reg_w = 1'b0, id_mem_to_reg = 1'b0, id_mem_write = 1'b0;
    logic [RAW-1:0] id_rs = '0, id_rt = '0, id_dst = '0;
    logic           id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic           ex_pc_src = 1'b0, dmem_ready = 1'b1;
    logic           pc_en, ifid_en, ifid_flush, dmem_req;
    logic           ex_mem_to_reg, ex_mem_write, ex_reg_w;
    logic           mem_mem_to_reg, mem_mem_write, mem_reg_w;
    logic           wb_mem_to_reg, wb_reg_w;
    logic [RAW-1:0] wb_dst;
    logic [1:0]     fwd_a, fwd_b;

    pipe_hazard_sched #(.RAW(RAW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_reg_w(id_reg_w), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_pc_src(ex_pc_src), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .dmem_req(dmem_req),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_reg_w(ex_reg_w),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_mem_write(mem_mem_write),
        .mem_reg_w(mem_reg_w),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_w(wb_reg_w), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    // One in-flight instruction's control.
    typedef struct packed {
        logic           rw;
        logic           m2r;
        logic           mw;
        logic [RAW-1:0] rs;
        logic [RAW-1:0] rt;
        logic [RAW-1:0] dst;
    } instr_t;

    typedef struct packed {
        int          cyc;
        logic [OW-1:0] exp;
    } item_t;

    instr_t ex_i, mem_i, wb_i;
    item_t  sb[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;
    bit     stim_done = 0;

    function automatic logic [1:0] m_fwd(input logic [RAW-1:0] src, input instr_t m,
                                         input instr_t w);
        if (m.rw && m.dst != 0 && m.dst == src) return 2'b10;
        if (w.rw && w.dst != 0 && w.dst == src) return 2'b01;
        return 2'b00;
    endfunction

    // Drive one cycle of inputs (mid-cycle, so reset may land between edges), predict, push.
    task automatic step(input logic rst, input logic rw, input logic m2r, input logic mw,
                        input int rs, input int rt, input int dst, input logic urs,
                        input logic urt, input logic pcs, input logic rdy);
        instr_t id;
        logic   frz, fl, lu, dreq, pce;
        @(posedge clk);
        #2;
        rst_n = rst; id_reg_w = rw; id_mem_to_reg = m2r; id_mem_write = mw;
        id_rs = RAW'(rs); id_rt = RAW'(rt); id_dst = RAW'(dst);
        id_uses_rs = urs; id_uses_rt = urt; ex_pc_src = pcs; dmem_ready = rdy;
        id = '{rw: rw, m2r: m2r, mw: mw, rs: RAW'(rs), rt: RAW'(rt), dst: RAW'(dst)};
        if (!rst) begin
            ex_i = '0; mem_i = '0; wb_i = '0;
        end
        dreq = mem_i.m2r | mem_i.mw;
        frz  = dreq & ~rdy;
        fl   = pcs & ~frz;
        lu   = ex_i.m2r && ex_i.dst != 0 &&
               ((urs && id.rs == ex_i.dst) || (urt && id.rt == ex_i.dst));
        pce  = frz ? 1'b0 : (fl ? 1'b1 : !lu);
        sb.push_back('{cyc: cyc, exp: {pce, pce, fl, dreq, ex_i.m2r, ex_i.mw, ex_i.rw,
                                       mem_i.m2r, mem_i.mw, mem_i.rw, wb_i.m2r, wb_i.rw,
                                       wb_i.dst, m_fwd(ex_i.rs, mem_i, wb_i),
                                       m_fwd(ex_i.rt, mem_i, wb_i)}});
        cyc++;
        // State seen after the coming edge.
        if (rst) begin
            if (frz) begin
                wb_i = '0;
            end else begin
                wb_i  = mem_i;
                mem_i = ex_i;
                ex_i  = (fl || lu) ? '0 : id;
            end
        end
    endtask

    task automatic nop(input logic pcs, input logic rdy);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, pcs, rdy);
    endtask

    task automatic rand_step(input logic rst);
        logic [2:0] kind = 3'($urandom_range(0, 7));
        step(rst, kind != 3'd2, kind <= 3'd1, kind == 3'd2,
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    endtask

    // Monitor: compare at the falling edge, well away from the rising edge and input changes.
    initial begin
        item_t it;
        logic [OW-1:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = {pc_en, ifid_en, ifid_flush, dmem_req, ex_mem_to_reg, ex_mem_write,
                       ex_reg_w, mem_mem_to_reg, mem_mem_write, mem_reg_w, wb_mem_to_reg,
                       wb_reg_w, wb_dst, fwd_a, fwd_b};
                tests++;
                if (act !== it.exp) begin
                    fails++;
                    $display("FAIL cycle%0d outputs: got %b expected %b", it.cyc, act, it.exp);
                end
            end
        end
    end

    initial begin
        ex_i = '0; mem_i = '0; wb_i = '0;
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) rand_step(1'b0);
        // Release: $8 writer reaches WB three edges later.
        step(1'b1, 1, 0, 0, 0, 0, 8, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) nop(0, 1);
        // lw $8 ; add $9,$8,$10 (re-presented after the stall).
        step(1'b1, 1, 1, 0, 0, 0, 8, 0, 0, 0, 1);
        step(1'b1, 1, 0, 0, 8, 10, 9, 1, 1, 0, 1);
        step(1'b1, 1, 0, 0, 8, 10, 9, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) nop(0, 1);
        // add $5 ; sub uses $5 as rt, then the same with $0.
        step(1'b1, 1, 0, 0, 1, 2, 5, 1, 1, 0, 1);
        step(1'b1, 1, 0, 0, 3, 5, 6, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) nop(0, 1);
        step(1'b1, 1, 0, 0, 1, 2, 0, 1, 1, 0, 1);
        step(1'b1, 1, 0, 0, 3, 0, 6, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) nop(0, 1);
        // Taken branch with an ALU op behind it.
        step(1'b1, 1, 0, 0, 1, 2, 7, 1, 1, 0, 1);
        step(1'b1, 1, 0, 0, 1, 2, 4, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) nop(0, 1);
        // sw reaches MEM, waits 3 cycles while a branch is pending.
        step(1'b1, 0, 0, 1, 1, 2, 0, 1, 1, 0, 1);
        step(1'b1, 1, 0, 0, 1, 2, 3, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) nop(1, 0);
        nop(1, 1);
        for (int i = 0; i < 3; i++) nop(0, 1);
        // Async reset in the middle of a freeze.
        step(1'b1, 0, 1, 0, 0, 0, 2, 0, 0, 0, 1);
        nop(0, 1);
        nop(0, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) nop(0, 1);
        // Random traffic with rare resets.
        for (int i = 0; i < 600; i++) rand_step($urandom_range(0, 99) != 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
